// File: rtl/control_alu_if.sv
// Bus between the ALU sequencing controller and its environment (operand bus, ALU, display).
// master: the controller side. slave: the environment that feeds operands and hosts the ALU.
interface control_alu_if #(
   parameter int unsigned N = 4
);
   logic [N-1:0] dato_in;
   logic         cargar;
   logic         cancelar;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [3:0]   alu_sel;
   logic         alu_flagin;
   logic [N-1:0] alu_result;
   logic         alu_overflow;
   logic         alu_negativo;
   logic         alu_cout;
   logic         alu_zero;
   logic [N-1:0] resultado;
   logic [3:0]   flags;
   logic [2:0]   estado;
   logic         listo;
   logic [7:0]   num_ops;

   modport master (
      input  dato_in, cargar, cancelar,
      input  alu_result, alu_overflow, alu_negativo, alu_cout, alu_zero,
      output alu_a, alu_b, alu_sel, alu_flagin,
      output resultado, flags, estado, listo, num_ops
   );

   modport slave (
      output dato_in, cargar, cancelar,
      output alu_result, alu_overflow, alu_negativo, alu_cout, alu_zero,
      input  alu_a, alu_b, alu_sel, alu_flagin,
      input  resultado, flags, estado, listo, num_ops
   );
endinterface

// File: rtl/control_alu.sv
// Collects A, B and opcode from a shared bus, drives the ALU for ALU_LAT settle cycles,
// then latches result and flags for display; the captured carry feeds the next operation.
module control_alu #(
   parameter int unsigned N       = 4,
   parameter int unsigned ALU_LAT = 1
) (
   input logic           clk,
   input logic           rst_n,
   control_alu_if.master bus
);
   typedef enum logic [2:0] {
      EsperaA  = 3'd0,
      EsperaB  = 3'd1,
      EsperaOp = 3'd2,
      Ejecuta  = 3'd3,
      Captura  = 3'd4,
      Muestra  = 3'd5
   } estado_e;

   localparam logic [3:0] LatLast = 4'(ALU_LAT - 1);

   // Plain vector so the unused codes 6 and 7 are representable and recoverable.
   logic [2:0]   r_estado;
   logic [3:0]   r_cnt;
   logic [N-1:0] r_alu_a;
   logic [N-1:0] r_alu_b;
   logic [3:0]   r_alu_sel;
   logic         r_alu_flagin;
   logic [N-1:0] r_resultado;
   logic [3:0]   r_flags;
   logic         r_listo;
   logic [7:0]   r_num_ops;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_estado     <= EsperaA;
         r_cnt        <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_sel    <= '0;
         r_alu_flagin <= 1'b0;
         r_resultado  <= '0;
         r_flags      <= '0;
         r_listo      <= 1'b0;
         r_num_ops    <= '0;
      end else if (bus.cancelar) begin
         r_estado <= EsperaA;
         r_listo  <= 1'b0;
      end else begin
         case (r_estado)
            EsperaA: begin
               if (bus.cargar) begin
                  r_alu_a  <= bus.dato_in;
                  r_estado <= EsperaB;
               end
            end
            EsperaB: begin
               if (bus.cargar) begin
                  r_alu_b  <= bus.dato_in;
                  r_estado <= EsperaOp;
               end
            end
            EsperaOp: begin
               if (bus.cargar) begin
                  r_alu_sel <= bus.dato_in[3:0];
                  r_cnt     <= '0;
                  r_estado  <= Ejecuta;
               end
            end
            Ejecuta: begin
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == LatLast) r_estado <= Captura;
            end
            Captura: begin
               r_resultado  <= bus.alu_result;
               r_flags      <= {bus.alu_negativo, bus.alu_zero, bus.alu_cout, bus.alu_overflow};
               r_alu_flagin <= bus.alu_cout;
               r_num_ops    <= r_num_ops + 8'd1;
               r_estado     <= Muestra;
            end
            Muestra: begin
               // A load here is operand A of the next operation.
               if (bus.cargar) begin
                  r_alu_a  <= bus.dato_in;
                  r_listo  <= 1'b0;
                  r_estado <= EsperaB;
               end else begin
                  r_listo <= 1'b1;
               end
            end
            default: r_estado <= EsperaA;
         endcase
      end
   end

   assign bus.alu_a      = r_alu_a;
   assign bus.alu_b      = r_alu_b;
   assign bus.alu_sel    = r_alu_sel;
   assign bus.alu_flagin = r_alu_flagin;
   assign bus.resultado  = r_resultado;
   assign bus.flags      = r_flags;
   assign bus.estado     = r_estado;
   assign bus.listo      = r_listo;
   assign bus.num_ops    = r_num_ops;
endmodule
